// File: rtl/axil_sram_slave.sv
// AXI-Lite word-organised SRAM responder, one outstanding transaction, fixed latency.
// Define AXIL_SRAM_RANDOM_DELAY_EN to add 0..3 LFSR-driven extra wait cycles per transaction.
module axil_sram_slave #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           STRB_WIDTH  = 4,
  parameter int unsigned           DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned           RD_LATENCY  = 1,
  parameter int unsigned           WR_LATENCY  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i
);

  localparam int unsigned           IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned           CNT_W = 16;
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * DEPTH_WORDS);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t                  state;
  logic                    aw_got, w_got;
  logic [CNT_W-1:0]        cnt, extra, rd_load, wr_load;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, aw_addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic                    idle, ar_hs, aw_hs, w_hs, wr_go, wr_fire, mem_we;
  logic                    rd_in, wr_in;
  logic [ADDR_WIDTH-1:0]   rd_addr, wr_addr, rd_off, wr_off;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_WIDTH-1:0]   wr_strb;
  logic [IDX_W-1:0]        rd_idx, wr_idx;

  assign idle      = (state == IDLE);
  // A fresh read beats a fresh write; a half-held write blocks reads.
  assign arready_o = idle && !aw_got && !w_got;
  assign awready_o = idle && !aw_got && !(arvalid_i && !w_got);
  assign wready_o  = idle && !w_got && !(arvalid_i && !aw_got);

  assign ar_hs = arvalid_i && arready_o;
  assign aw_hs = awvalid_i && awready_o;
  assign w_hs  = wvalid_i && wready_o;
  assign wr_go = idle && (aw_got || aw_hs) && (w_got || w_hs);

`ifdef AXIL_SRAM_RANDOM_DELAY_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign extra = {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
  assign extra = '0;
`endif

  assign rd_load = CNT_W'(RD_LATENCY - 1) + extra;
  assign wr_load = CNT_W'(WR_LATENCY - 1) + extra;

  always_comb begin
    rd_addr = idle ? araddr_i : rd_addr_q;
    wr_addr = aw_got ? aw_addr_q : awaddr_i;
    wr_data = w_got ? wdata_q : wdata_i;
    wr_strb = w_got ? wstrb_q : wstrb_i;
    rd_off  = rd_addr - BASE_ADDR;
    wr_off  = wr_addr - BASE_ADDR;
    rd_in   = (rd_off < SPAN);
    wr_in   = (wr_off < SPAN);
    rd_idx  = rd_off[IDX_W+1:2];
    wr_idx  = wr_off[IDX_W+1:2];
  end

  assign wr_fire = (wr_go && (wr_load == '0)) || ((state == WR_WAIT) && (cnt == '0));
  assign mem_we  = wr_fire && wr_in && !rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // A zero load skips the WAIT state so latency 1 answers right after the handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      cnt       <= '0;
      rd_addr_q <= '0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rvalid_o  <= 1'b0;
      bvalid_o  <= 1'b0;
      rdata_o   <= '0;
      rresp_o   <= RESP_OKAY;
      bresp_o   <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            rd_addr_q <= araddr_i;
            if (rd_load == '0) begin
              rdata_o  <= rd_in ? mem[rd_idx] : '0;
              rresp_o  <= rd_in ? RESP_OKAY : RESP_DECERR;
              rvalid_o <= 1'b1;
              state    <= RD_RESP;
            end else begin
              cnt   <= rd_load - CNT_W'(1);
              state <= RD_WAIT;
            end
          end else begin
            if (aw_hs) begin
              aw_addr_q <= awaddr_i;
              aw_got    <= 1'b1;
            end
            if (w_hs) begin
              wdata_q <= wdata_i;
              wstrb_q <= wstrb_i;
              w_got   <= 1'b1;
            end
            if (wr_go) begin
              if (wr_load == '0) begin
                bresp_o  <= wr_in ? RESP_OKAY : RESP_DECERR;
                bvalid_o <= 1'b1;
                state    <= WR_RESP;
              end else begin
                cnt   <= wr_load - CNT_W'(1);
                state <= WR_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            rdata_o  <= rd_in ? mem[rd_idx] : '0;
            rresp_o  <= rd_in ? RESP_OKAY : RESP_DECERR;
            rvalid_o <= 1'b1;
            state    <= RD_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_RESP: begin
          if (rready_i) begin
            rvalid_o <= 1'b0;
            state    <= IDLE;
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            bresp_o  <= wr_in ? RESP_OKAY : RESP_DECERR;
            bvalid_o <= 1'b1;
            state    <= WR_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_RESP: begin
          if (bready_i) begin
            bvalid_o <= 1'b0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
